gpu_bg_block_xfer: RTL and testbench

- Downstream stage of the GPU pixel backend. It consumes the backend's BG-block pair code, exported 16-pixel block, write mask, and load/save block addresses.
- It moves 256-bit background blocks between the backend and the VRAM/DDR memory port, and returns loaded blocks through a single-cycle import strobe.
- It stalls the pixel pipeline for the duration of each block operation, then releases it with mask/spike reset pulses.

---
 rtl/gpu_bg_pkg.sv | 28 ++
 rtl/gpu_bg_beat_packer.sv | 41 ++++
 rtl/gpu_bg_block_xfer.sv | 215 +++++++++++++++++++++
 tb/tb_gpu_bg_block_xfer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_bg_pkg.sv
// Shared constants for the GPU background block transfer engine: pair codes,
// block geometry, FSM state encodings and a saturating counter helper.
package gpu_bg_pkg;

  localparam int BG_BLOCK_W = 256;
  localparam int BG_ADR_W   = 15;
  localparam int BG_MSK_W   = 16;

  localparam logic [1:0] PAIR_NONE  = 2'b00;
  localparam logic [1:0] PAIR_FIRST = 2'b01;
  localparam logic [1:0] PAIR_NEXT  = 2'b10;
  localparam logic [1:0] PAIR_LAST  = 2'b11;

  typedef logic [2:0] bg_state_t;

  localparam bg_state_t ST_IDLE      = 3'd0;
  localparam bg_state_t ST_SAVE_CMD  = 3'd1;
  localparam bg_state_t ST_SAVE_DATA = 3'd2;
  localparam bg_state_t ST_LOAD_CMD  = 3'd3;
  localparam bg_state_t ST_LOAD_DATA = 3'd4;
  localparam bg_state_t ST_IMPORT    = 3'd5;
  localparam bg_state_t ST_DONE      = 3'd6;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/gpu_bg_beat_packer.sv
// Slices a 256-bit block and 16-bit pixel mask into memory beats/byte enables,
// and merges an incoming read beat into the block assembly buffer.
module gpu_bg_beat_packer
  import gpu_bg_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [BG_BLOCK_W-1:0] i_block,
  input  logic [BG_MSK_W-1:0]   i_mask,
  input  logic [1:0]            i_beat,
  input  logic [BG_BLOCK_W-1:0] i_rbuf,
  input  logic [DATA_W-1:0]     i_rdata,
  output logic [DATA_W-1:0]     o_wdata,
  output logic [DATA_W/8-1:0]   o_wbyteen,
  output logic [BG_BLOCK_W-1:0] o_rbuf_next
);

  localparam int BEATS = BG_BLOCK_W / DATA_W;
  localparam int BYTES = DATA_W / 8;

  logic [3:0] pix;

  // Each pixel is 16 bits, so two consecutive bytes share one mask bit.
  always_comb begin
    o_wdata     = '0;
    o_wbyteen   = '0;
    o_rbuf_next = i_rbuf;
    pix         = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (i_beat == k[1:0]) begin
        o_wdata = i_block[k*DATA_W +: DATA_W];
        o_rbuf_next[k*DATA_W +: DATA_W] = i_rdata;
        for (int j = 0; j < BYTES; j++) begin
          pix          = 4'((k * BYTES + j) / 2);
          o_wbyteen[j] = i_mask[pix];
        end
      end
    end
  end

endmodule

// File: rtl/gpu_bg_block_xfer.sv
// Moves 256-bit BG blocks between the pixel backend and the memory port.
// Optional performance counters are enabled with `define GPU_BGXFER_PERF_CNT_EN.
module gpu_bg_block_xfer
  import gpu_bg_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_saveBGBlock,
  input  logic                  i_noblend,
  input  logic [BG_ADR_W-1:0]   i_loadAdr,
  input  logic [BG_ADR_W-1:0]   i_saveAdr,
  input  logic [BG_BLOCK_W-1:0] i_exportedBGBlock,
  input  logic [BG_MSK_W-1:0]   i_exportedMSKBGBlock,
  output logic                  o_pausePipeline,
  output logic                  o_importBGBlockSingleClock,
  output logic [BG_BLOCK_W-1:0] o_importedBGBlock,
  output logic                  o_resetPixelMask,
  output logic                  o_resetPipelinePixelStateSpike,
  output logic                  o_flushDone,
  output logic                  o_cmdValid,
  input  logic                  i_cmdReady,
  output logic                  o_cmdWrite,
  output logic [BG_ADR_W-1:0]   o_cmdAdr,
  output logic                  o_wValid,
  input  logic                  i_wReady,
  output logic [DATA_W-1:0]     o_wData,
  output logic [DATA_W/8-1:0]   o_wByteEn,
  input  logic                  i_rValid,
  input  logic [DATA_W-1:0]     i_rData
`ifdef GPU_BGXFER_PERF_CNT_EN
  ,
  output logic [31:0]           o_perfLoads,
  output logic [31:0]           o_perfSaves,
  output logic [31:0]           o_perfStallCycles
`endif
);

  localparam int         BEATS     = BG_BLOCK_W / DATA_W;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  bg_state_t             state_q, state_d;
  logic                  armed_q, armed_d;
  logic [1:0]            code_q, code_d;
  logic                  noblend_q, noblend_d;
  logic [BG_ADR_W-1:0]   load_adr_q, load_adr_d;
  logic [BG_ADR_W-1:0]   save_adr_q, save_adr_d;
  logic [BG_BLOCK_W-1:0] block_q, block_d;
  logic [BG_MSK_W-1:0]   mask_q, mask_d;
  logic [1:0]            beat_q, beat_d;
  logic [BG_BLOCK_W-1:0] buf_q, buf_d;

  logic [DATA_W-1:0]     pk_wdata;
  logic [DATA_W/8-1:0]   pk_wbyteen;
  logic [BG_BLOCK_W-1:0] pk_rbuf;

  logic accept, in_save, in_load, snap_load, snap_save, pause;

  gpu_bg_beat_packer #(.DATA_W(DATA_W)) u_packer (
    .i_block     (block_q),
    .i_mask      (mask_q),
    .i_beat      (beat_q),
    .i_rbuf      (buf_q),
    .i_rdata     (i_rData),
    .o_wdata     (pk_wdata),
    .o_wbyteen   (pk_wbyteen),
    .o_rbuf_next (pk_rbuf)
  );

  // Work required by the incoming code (in_*) and by the captured snapshot (snap_*).
  assign in_save   = (i_saveBGBlock != PAIR_FIRST) && (i_exportedMSKBGBlock != '0);
  assign in_load   = (i_saveBGBlock == PAIR_FIRST) || ((i_saveBGBlock == PAIR_NEXT) && !i_noblend);
  assign snap_save = (code_q != PAIR_FIRST) && (mask_q != '0);
  assign snap_load = (code_q == PAIR_FIRST) || ((code_q == PAIR_NEXT) && !noblend_q);

  assign accept = (state_q == ST_IDLE) && (i_saveBGBlock != PAIR_NONE) && !armed_q;
  // Reset also masks the combinational stall term so every output reads 0 in reset.
  assign pause  = !i_rst && ((state_q != ST_IDLE) || ((i_saveBGBlock != PAIR_NONE) && !armed_q));

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    code_d     = code_q;
    noblend_d  = noblend_q;
    load_adr_d = load_adr_q;
    save_adr_d = save_adr_q;
    block_d    = block_q;
    mask_d     = mask_q;
    beat_d     = beat_q;
    buf_d      = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (i_saveBGBlock == PAIR_NONE) armed_d = 1'b0;
        if (accept) begin
          armed_d    = 1'b1;
          code_d     = i_saveBGBlock;
          noblend_d  = i_noblend;
          load_adr_d = i_loadAdr;
          save_adr_d = i_saveAdr;
          block_d    = i_exportedBGBlock;
          mask_d     = i_exportedMSKBGBlock;
          beat_d     = '0;
          if (in_save)      state_d = ST_SAVE_CMD;
          else if (in_load) state_d = ST_LOAD_CMD;
          else              state_d = ST_DONE;
        end
      end
      ST_SAVE_CMD:  if (i_cmdReady) state_d = ST_SAVE_DATA;
      ST_SAVE_DATA: begin
        if (i_wReady) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = snap_load ? ST_LOAD_CMD : ST_DONE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      ST_LOAD_CMD:  if (i_cmdReady) state_d = ST_LOAD_DATA;
      ST_LOAD_DATA: begin
        if (i_rValid) begin
          buf_d = pk_rbuf;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_IMPORT;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      ST_IMPORT: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      code_q     <= PAIR_NONE;
      noblend_q  <= 1'b0;
      load_adr_q <= '0;
      save_adr_q <= '0;
      block_q    <= '0;
      mask_q     <= '0;
      beat_q     <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      code_q     <= code_d;
      noblend_q  <= noblend_d;
      load_adr_q <= load_adr_d;
      save_adr_q <= save_adr_d;
      block_q    <= block_d;
      mask_q     <= mask_d;
      beat_q     <= beat_d;
      buf_q      <= buf_d;
    end
  end

  always_comb begin
    o_pausePipeline                = pause;
    o_cmdValid                     = (state_q == ST_SAVE_CMD) || (state_q == ST_LOAD_CMD);
    o_cmdWrite                     = (state_q == ST_SAVE_CMD);
    o_cmdAdr                       = '0;
    if (state_q == ST_SAVE_CMD) o_cmdAdr = save_adr_q;
    if (state_q == ST_LOAD_CMD) o_cmdAdr = load_adr_q;
    o_wValid                       = (state_q == ST_SAVE_DATA);
    o_wData                        = (state_q == ST_SAVE_DATA) ? pk_wdata : '0;
    o_wByteEn                      = (state_q == ST_SAVE_DATA) ? pk_wbyteen : '0;
    o_importBGBlockSingleClock     = (state_q == ST_IMPORT);
    o_importedBGBlock              = (state_q == ST_IMPORT) ? buf_q : '0;
    // When a load runs, IMPORT already cleared the mask; otherwise DONE does it after a save.
    o_resetPixelMask               = (state_q == ST_IMPORT) ||
                                     ((state_q == ST_DONE) && !snap_load && snap_save);
    o_resetPipelinePixelStateSpike = (state_q == ST_DONE);
    o_flushDone                    = (state_q == ST_DONE) && (code_q == PAIR_LAST);
  end

`ifdef GPU_BGXFER_PERF_CNT_EN
  logic [31:0] perf_loads_q, perf_loads_d;
  logic [31:0] perf_saves_q, perf_saves_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_loads_d = perf_loads_q;
    perf_saves_d = perf_saves_q;
    perf_stall_d = perf_stall_q;
    if (state_q == ST_IMPORT) perf_loads_d = sat_inc32(perf_loads_q);
    if ((state_q == ST_SAVE_DATA) && i_wReady && (beat_q == LAST_BEAT))
      perf_saves_d = sat_inc32(perf_saves_q);
    if (pause) perf_stall_d = sat_inc32(perf_stall_q);
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      perf_loads_q <= '0;
      perf_saves_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_loads_q <= perf_loads_d;
      perf_saves_q <= perf_saves_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign o_perfLoads       = perf_loads_q;
  assign o_perfSaves       = perf_saves_q;
  assign o_perfStallCycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_gpu_bg_block_xfer.sv
// Directed bench for gpu_bg_block_xfer (DATA_W=64): inputs change on the falling
// edge, outputs are checked 1 time unit later.
module tb_gpu_bg_block_xfer;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   code;
  logic         noblend;
  logic [14:0]  load_adr, save_adr;
  logic [255:0] block;
  logic [15:0]  mask;
  logic         pause, strobe, rpm, spike, flush;
  logic [255:0] imported;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [14:0]  cmd_adr;
  logic         w_valid, w_ready;
  logic [63:0]  w_data;
  logic [7:0]   w_be;
  logic         r_valid;
  logic [63:0]  r_data;
`ifdef GPU_BGXFER_PERF_CNT_EN
  logic [31:0]  perf_loads, perf_saves, perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] blk2, blk3;
  logic [63:0]  beat_exp;

  always #5 clk = ~clk;

  gpu_bg_block_xfer #(.DATA_W(64)) dut (
    .clk                            (clk),
    .i_rst                          (rst),
    .i_saveBGBlock                  (code),
    .i_noblend                      (noblend),
    .i_loadAdr                      (load_adr),
    .i_saveAdr                      (save_adr),
    .i_exportedBGBlock              (block),
    .i_exportedMSKBGBlock           (mask),
    .o_pausePipeline                (pause),
    .o_importBGBlockSingleClock     (strobe),
    .o_importedBGBlock              (imported),
    .o_resetPixelMask               (rpm),
    .o_resetPipelinePixelStateSpike (spike),
    .o_flushDone                    (flush),
    .o_cmdValid                     (cmd_valid),
    .i_cmdReady                     (cmd_ready),
    .o_cmdWrite                     (cmd_write),
    .o_cmdAdr                       (cmd_adr),
    .o_wValid                       (w_valid),
    .i_wReady                       (w_ready),
    .o_wData                        (w_data),
    .o_wByteEn                      (w_be),
    .i_rValid                       (r_valid),
    .i_rData                        (r_data)
`ifdef GPU_BGXFER_PERF_CNT_EN
    ,
    .o_perfLoads                    (perf_loads),
    .o_perfSaves                    (perf_saves),
    .o_perfStallCycles              (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic ok);
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; code = 2'b00; noblend = 1'b0; load_adr = '0; save_adr = '0;
    block = '0; mask = '0; cmd_ready = 1'b1; w_ready = 1'b1; r_valid = 1'b0; r_data = '0;
    blk2 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    blk3 = {64'hDDDD_0004_DDDD_0004, 64'hCCCC_0003_CCCC_0003,
            64'hBBBB_0002_BBBB_0002, 64'hAAAA_0001_AAAA_0001};
    repeat (2) nx();

    // Reset state, with a pending code that must not leak through.
    code = 2'b01; #1;
    chk("rst_pause", pause === 1'b0);
    chk("rst_cmd_valid", cmd_valid === 1'b0);
    chk("rst_w_valid", w_valid === 1'b0);
    chk("rst_strobe", strobe === 1'b0);
    chk("rst_spike", spike === 1'b0);
    chk("rst_flush", flush === 1'b0);
    chk("rst_rpm", rpm === 1'b0);
    nx(); rst = 1'b0; code = 2'b00; #1;
    chk("idle_pause", pause === 1'b0);

    // Code 01: load only, with a stray read beat during the command cycle.
    nx(); code = 2'b01; load_adr = 15'h1234; #1;
    chk("t1_accept_pause", pause === 1'b1);
    chk("t1_accept_cmd", cmd_valid === 1'b0);
    nx(); r_valid = 1'b1; r_data = 64'hBAD; #1;
    chk("t1_cmd_valid", cmd_valid === 1'b1);
    chk("t1_cmd_write", cmd_write === 1'b0);
    chk("t1_cmd_adr", cmd_adr === 15'h1234);
    for (int i = 0; i < 4; i++) begin
      nx(); r_data = 64'hA + 64'(i); #1;
      chk("t1_rd_pause", pause === 1'b1);
      chk("t1_rd_cmd", cmd_valid === 1'b0);
    end
    nx(); r_valid = 1'b0; #1;
    chk("t1_strobe", strobe === 1'b1);
    chk("t1_imported", imported === {64'hD, 64'hC, 64'hB, 64'hA});
    chk("t1_imp_rpm", rpm === 1'b1);
    chk("t1_imp_spike", spike === 1'b0);
    nx(); #1;
    chk("t1_spike", spike === 1'b1);
    chk("t1_done_rpm", rpm === 1'b0);
    chk("t1_done_flush", flush === 1'b0);
    chk("t1_done_strobe", strobe === 1'b0);
    chk("t1_done_pause", pause === 1'b1);
    nx(); #1;
    chk("t1_after_pause", pause === 1'b0);
    chk("t1_after_spike", spike === 1'b0);

    // Code 10: save (mask 0x0003) then load; inputs change while busy.
    nx(); code = 2'b00; #1;
    nx(); code = 2'b10; mask = 16'h0003; save_adr = 15'h0010; load_adr = 15'h0011; block = blk2; #1;
    chk("t2_accept_pause", pause === 1'b1);
    nx(); code = 2'b11; block = '0; mask = '0; load_adr = 15'h7FFF; save_adr = 15'h7FFF; #1;
    chk("t2_cmd_valid", cmd_valid === 1'b1);
    chk("t2_cmd_write", cmd_write === 1'b1);
    chk("t2_cmd_adr", cmd_adr === 15'h0010);
    for (int k = 0; k < 4; k++) begin
      nx(); #1;
      beat_exp = blk2[k*64 +: 64];
      chk("t2_w_valid", w_valid === 1'b1);
      chk("t2_w_data", w_data === beat_exp);
      chk("t2_w_be", w_be === ((k == 0) ? 8'h0F : 8'h00));
    end
    nx(); #1;
    chk("t2_rd_cmd_valid", cmd_valid === 1'b1);
    chk("t2_rd_cmd_write", cmd_write === 1'b0);
    chk("t2_rd_cmd_adr", cmd_adr === 15'h0011);
    chk("t2_rd_w_valid", w_valid === 1'b0);
    for (int k = 0; k < 4; k++) begin
      nx(); r_valid = 1'b1; r_data = 64'h5 + 64'(k); #1;
    end
    nx(); r_valid = 1'b0; #1;
    chk("t2_strobe", strobe === 1'b1);
    chk("t2_imported", imported === {64'h8, 64'h7, 64'h6, 64'h5});
    chk("t2_imp_rpm", rpm === 1'b1);
    nx(); #1;
    chk("t2_spike", spike === 1'b1);
    chk("t2_done_flush", flush === 1'b0);
    chk("t2_done_rpm", rpm === 1'b0);
    nx(); #1;
    chk("t2_held_pause", pause === 1'b0);
    nx(); #1;
    chk("t2_held_pause2", pause === 1'b0);
    chk("t2_held_cmd", cmd_valid === 1'b0);

    // Code 11: flush with command and write-beat back-pressure.
    nx(); code = 2'b00; #1;
    nx(); code = 2'b11; mask = 16'hFFFF; save_adr = 15'h0ABC; block = blk3; #1;
    chk("t3_accept_pause", pause === 1'b1);
    nx(); cmd_ready = 1'b0; #1;
    chk("t3_cmd_valid", cmd_valid === 1'b1);
    chk("t3_cmd_adr", cmd_adr === 15'h0ABC);
    chk("t3_cmd_write", cmd_write === 1'b1);
    nx(); cmd_ready = 1'b1; #1;
    chk("t3_cmd_hold_valid", cmd_valid === 1'b1);
    chk("t3_cmd_hold_adr", cmd_adr === 15'h0ABC);
    for (int k = 0; k < 2; k++) begin
      nx(); #1;
      beat_exp = blk3[k*64 +: 64];
      chk("t3_w_data", w_data === beat_exp);
      chk("t3_w_be", w_be === 8'hFF);
    end
    beat_exp = blk3[2*64 +: 64];
    for (int s = 0; s < 6; s++) begin
      nx(); w_ready = (s == 5); #1;
      chk("t3_stall_valid", w_valid === 1'b1);
      chk("t3_stall_data", w_data === beat_exp);
      chk("t3_stall_be", w_be === 8'hFF);
    end
    nx(); #1;
    beat_exp = blk3[3*64 +: 64];
    chk("t3_w_data3", w_data === beat_exp);
    nx(); #1;
    chk("t3_spike", spike === 1'b1);
    chk("t3_flush", flush === 1'b1);
    chk("t3_done_rpm", rpm === 1'b1);
    chk("t3_done_cmd", cmd_valid === 1'b0);
    nx(); #1;
    chk("t3_flush_once", flush === 1'b0);
    chk("t3_after_pause", pause === 1'b0);
    chk("t3_after_cmd", cmd_valid === 1'b0);

    // Code 10 with empty mask and noblend: straight to DONE, then re-arm rules.
    nx(); code = 2'b00; #1;
    nx(); code = 2'b10; mask = 16'h0000; noblend = 1'b1; #1;
    chk("t4_accept_pause", pause === 1'b1);
    nx(); #1;
    chk("t4_spike", spike === 1'b1);
    chk("t4_rpm", rpm === 1'b0);
    chk("t4_cmd", cmd_valid === 1'b0);
    chk("t4_done_pause", pause === 1'b1);
    nx(); #1;
    chk("t4_held_pause", pause === 1'b0);
    chk("t4_held_spike", spike === 1'b0);
    nx(); #1;
    chk("t4_held_pause2", pause === 1'b0);
    nx(); code = 2'b00; #1;
    nx(); code = 2'b10; #1;
    chk("t5_reaccept_pause", pause === 1'b1);
    nx(); #1;
    chk("t5_reaccept_spike", spike === 1'b1);
    nx(); code = 2'b00; noblend = 1'b0; #1;

    // Reset in the middle of a load, then a clean load.
    nx(); code = 2'b01; load_adr = 15'h0077; #1;
    chk("t6_accept_pause", pause === 1'b1);
    nx(); #1;
    chk("t6_cmd_adr", cmd_adr === 15'h0077);
    nx(); r_valid = 1'b1; r_data = 64'h11;
    nx(); r_data = 64'h22;
    nx(); r_valid = 1'b0; rst = 1'b1; #1;
    chk("t6_rst_pause", pause === 1'b0);
    chk("t6_rst_cmd", cmd_valid === 1'b0);
    chk("t6_rst_strobe", strobe === 1'b0);
    chk("t6_rst_imported", imported === 256'h0);
    chk("t6_rst_spike", spike === 1'b0);
    chk("t6_rst_cmd_adr", cmd_adr === 15'h0);
    nx(); rst = 1'b0; #1;
    chk("t6_post_pause", pause === 1'b1);
    chk("t6_post_cmd", cmd_valid === 1'b0);
    nx(); #1;
    chk("t6_cmd_valid", cmd_valid === 1'b1);
    chk("t6_cmd_write", cmd_write === 1'b0);
    chk("t6_cmd_adr2", cmd_adr === 15'h0077);
    for (int k = 0; k < 4; k++) begin
      nx(); r_valid = 1'b1; r_data = 64'h91 + 64'(k); #1;
    end
    nx(); r_valid = 1'b0; #1;
    chk("t6_strobe", strobe === 1'b1);
    chk("t6_imported", imported === {64'h94, 64'h93, 64'h92, 64'h91});
    nx(); #1;
    chk("t6_spike", spike === 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
